// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: captures two WIDTH-bit operands and a carry-in,
// then adds them LSB-first through one full-adder cell, one bit per clock.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic             s, co;
  logic [WIDTH-1:0] r_shift;

  assign s  = a_q[0] ^ b_q[0] ^ c_q;
  assign co = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  // {s, r_q[WIDTH-1:1]} written as a widened shift so WIDTH=1 needs no special case
  assign r_shift = WIDTH'({s, r_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_d   = r_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = r_shift;
          cout_d  = co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk, rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_sum8;
  logic       exp_cout8;
  logic [0:0] exp_sum1;
  logic       exp_cout1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vt[12];

  task automatic add8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      input logic [7:0] es, input logic ec, input string tag);
    int  lat;
    logic held_ok;
    @(negedge clk);
    a = ai; b = bi; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ai; b = ~bi; cin = ~ci;
    chk({tag, "_busy_e0"}, busy, 1'b1);
    lat = 0;
    held_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (sum !== exp_sum8 || cout !== exp_cout8) held_ok = 1'b0;
      if (lat == 3) start = 1'b1;
      if (lat == 5) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_hold"}, held_ok, 1'b1);
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_busy_done"}, busy, 1'b1);
    exp_sum8  = es;
    exp_cout8 = ec;
    @(posedge clk); #1;
    chk({tag, "_done_width"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic add1(input logic ai, input logic bi, input logic ci,
                      input logic es, input logic ec, input string tag);
    int  lat;
    logic held_ok;
    @(negedge clk);
    a1 = ai; b1 = bi; cin1 = ci; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = ~ai; b1 = ~bi; cin1 = ~ci;
    lat = 0;
    held_ok = 1'b1;
    while (done1 !== 1'b1 && lat < 20) begin
      if (sum1 !== exp_sum1 || cout1 !== exp_cout1) held_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_hold"}, held_ok, 1'b1);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_sum"}, sum1, es);
    chk({tag, "_cout"}, cout1, ec);
    exp_sum1  = es;
    exp_cout1 = ec;
    @(posedge clk); #1;
    chk({tag, "_done_width"}, done1, 1'b0);
    chk({tag, "_idle"}, busy1, 1'b0);
  endtask

  initial begin
    int n;
    logic [8:0] r9;
    logic [1:0] r2;
    logic [7:0] ra, rb;
    logic       rc, qa, qb, qc;

    vt[0]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[1]  = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
    vt[2]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vt[3]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vt[4]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[5]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[6]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[7]  = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vt[8]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vt[9]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vt[10] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vt[11] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    exp_sum8 = '0; exp_cout8 = 1'b0; exp_sum1 = '0; exp_cout1 = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum1", sum1, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      add8(vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cout, $sformatf("vec%0d", i));

    // start held high: back-to-back adds, operands disturbed mid-add
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (done !== 1'b1 && n < 40);
    chk("cont_first_done", done, 1'b1);
    chk("cont_first_sum", sum, 8'h02);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
        if (n == 4) begin a = 8'hFF; b = 8'hFF; end
        if (n == 8) begin a = 8'h01; b = 8'h01; end
      end while (done !== 1'b1 && n < 40);
      chk("cont_period", n, 10);
      chk("cont_sum", sum, 8'h02);
      chk("cont_cout", cout, 1'b0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("cont_stop", busy, 1'b0);
    exp_sum8 = 8'h02; exp_cout8 = 1'b0;

    // asynchronous reset in the 4th SHIFT cycle
    add8(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, "pre_rst");
    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", sum, 8'h00);
    chk("arst_cout", cout, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    exp_sum8 = '0; exp_cout8 = 1'b0; exp_sum1 = '0; exp_cout1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    add8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "post_rst");

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      add8(ra, rb, rc, r9[7:0], r9[8], "rnd8");
    end

    for (int i = 0; i < 8; i++) begin
      r2 = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
      add1(i[0], i[1], i[2], r2[0], r2[1], $sformatf("w1_%0d", i));
    end
    for (int i = 0; i < 40; i++) begin
      qa = 1'($urandom); qb = 1'($urandom); qc = 1'($urandom);
      r2 = 2'(qa) + 2'(qb) + 2'(qc);
      add1(qa, qb, qc, r2[0], r2[1], "rnd1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
